// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32M multiply/divide sequencer.
//   m_state_t : sequencer states (IDLE, PREP, CALC, FIX, DONE)
//   m_op_t    : M-extension operation, encoded as the low three bits of m_func
//               (identical to the instruction funct3 field)
//   M_DIV_OVF_A, M_ALL_ONES : operand/result constants for the division
//               special cases
//   op_is_div / op_a_signed / op_b_signed : operation classification helpers
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam int unsigned M_XLEN = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } m_state_t;

   // Low bits of m_func; bit 2 separates the divide group from multiply.
   typedef enum logic [2:0] {
      M_MUL    = 3'b000,
      M_MULH   = 3'b001,
      M_MULHSU = 3'b010,
      M_MULHU  = 3'b011,
      M_DIV    = 3'b100,
      M_DIVU   = 3'b101,
      M_REM    = 3'b110,
      M_REMU   = 3'b111
   } m_op_t;

   localparam logic [M_XLEN-1:0] M_DIV_OVF_A = 32'h8000_0000;
   localparam logic [M_XLEN-1:0] M_ALL_ONES  = 32'hFFFF_FFFF;

   function automatic logic op_is_div(input m_op_t op);
      return (op == M_DIV) || (op == M_DIVU) || (op == M_REM) || (op == M_REMU);
   endfunction

   // MUL keeps only the low half, which is sign-agnostic, so it runs unsigned.
   function automatic logic op_a_signed(input m_op_t op);
      return (op == M_MULH) || (op == M_MULHSU) || (op == M_DIV) || (op == M_REM);
   endfunction

   function automatic logic op_b_signed(input m_op_t op);
      return (op == M_MULH) || (op == M_DIV) || (op == M_REM);
   endfunction

endpackage

// File: rtl/m_ext_datapath.sv
// ----------------------------------------------------------------------------
// m_ext_datapath
// Operand capture, radix-2 shift-add multiplier, restoring divider and sign
// fix-up for the RV32M sequencer. All sequencing comes from m_ext_seq.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   accept       latch funct3/op_a/op_b (request accepted in IDLE)
//   prep         PREP cycle: take magnitudes, record signs, seed registers
//   calc         CALC cycle: perform one multiply or divide iteration
//   commit       FIX cycle not flushed: register the final result
//   funct3       operation select
//   op_a, op_b   rs1 / rs2 values
//   special      divide-by-zero or signed-overflow case (valid in PREP)
//   result       registered result, held until the next commit
// ----------------------------------------------------------------------------
module m_ext_datapath
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            accept,
   input  logic            prep,
   input  logic            calc,
   input  logic            commit,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            special,
   output logic [XLEN-1:0] result
);

   // Conditional two's-complement negation helpers.
   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   m_op_t               fn_q;
   logic [XLEN-1:0]     a_q, b_q;
   logic [XLEN-1:0]     opnd_q;      // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   acc_q;       // product, or {remainder, quotient}
   logic                sign_res_q, sign_rem_q, spec_q;
   logic [XLEN-1:0]     spec_val_q;

   logic signed [XLEN-1:0] a_s, b_s;
   logic                neg_a, neg_b, is_div;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                div_zero, div_ovf;
   logic [XLEN-1:0]     spec_val;

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_rsh, div_diff;
   logic [2*XLEN-1:0]   div_next;

   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

   assign a_s    = a_q;
   assign b_s    = b_q;
   assign is_div = op_is_div(fn_q);
   assign neg_a  = op_a_signed(fn_q) && (a_s < 0);
   assign neg_b  = op_b_signed(fn_q) && (b_s < 0);
   assign mag_a  = neg_x(a_q, neg_a);
   assign mag_b  = neg_x(b_q, neg_b);

   assign div_zero = is_div && (b_q == '0);
   assign div_ovf  = ((fn_q == M_DIV) || (fn_q == M_REM)) &&
                     (a_q == M_DIV_OVF_A) && (b_q == M_ALL_ONES);
   assign special  = div_zero || div_ovf;

   // fn_q[1] selects REM/REMU within the divide group.
   always_comb begin
      spec_val = '0;
      if (div_zero) begin
         spec_val = fn_q[1] ? a_q : M_ALL_ONES;
      end else if (div_ovf) begin
         spec_val = fn_q[1] ? '0 : M_DIV_OVF_A;
      end
   end

   // Multiply step: add multiplicand to the upper half when the multiplier
   // LSB is set, then shift the whole register right (carry enters the MSB).
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                              : {1'b0, acc_q[2*XLEN-1:1]};

   // Restoring divide step: shift the next dividend bit into the partial
   // remainder, trial-subtract, keep the difference if it did not borrow.
   assign div_rsh  = acc_q[2*XLEN-1:XLEN-1];
   assign div_diff = div_rsh - {1'b0, opnd_q};
   assign div_next = div_diff[XLEN] ? {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   // Remainder takes the dividend sign; product and quotient take sign_res.
   assign prod_fix = neg_2x(acc_q, sign_res_q);
   assign quo_fix  = neg_x(acc_q[XLEN-1:0], sign_res_q);
   assign rem_fix  = neg_x(acc_q[2*XLEN-1:XLEN], sign_rem_q);

   always_comb begin
      fix_val = '0;
      if (spec_q) begin
         fix_val = spec_val_q;
      end else begin
         case (fn_q)
            M_MUL:                      fix_val = prod_fix[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:              fix_val = quo_fix;
            default:                    fix_val = rem_fix;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fn_q       <= M_MUL;
         a_q        <= '0;
         b_q        <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         sign_res_q <= 1'b0;
         sign_rem_q <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         result     <= '0;
      end else begin
         // Operand capture stage
         if (accept) begin
            fn_q <= m_op_t'(funct3);
            a_q  <= op_a;
            b_q  <= op_b;
         end
         // Magnitude/seed stage
         if (prep) begin
            spec_q     <= special;
            spec_val_q <= spec_val;
            sign_res_q <= neg_a ^ neg_b;
            sign_rem_q <= neg_a;
            opnd_q     <= is_div ? mag_b : mag_a;
            acc_q      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
         end
         // Iteration stage
         if (calc) begin
            acc_q <= is_div ? div_next : mul_next;
         end
         // Fix-up/commit stage
         if (commit) begin
            result <= fix_val;
         end
      end
   end

endmodule

// File: rtl/m_ext_seq.sv
// ----------------------------------------------------------------------------
// m_ext_seq
// Multi-cycle RV32M sequencer: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one
// bit per cycle. Owns the FSM and iteration counter; arithmetic lives in
// m_ext_datapath.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset (priority over everything)
//   start    request strobe, accepted only in IDLE with flush low
//   funct3   operation select
//   op_a     rs1 (multiplicand / dividend)
//   op_b     rs2 (multiplier / divisor)
//   flush    abort: any non-IDLE state returns to IDLE on the next edge
//   busy     high from the cycle after acceptance through the done cycle
//   done     one-cycle pulse, result valid in the same cycle
//   result   registered result, held until the next done
// ----------------------------------------------------------------------------
module m_ext_seq
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   m_state_t         state;
   logic [CNT_W-1:0] cnt;
   logic             accept, in_prep, in_calc, commit, special;

   assign accept  = (state == IDLE) && start && !flush;
   assign in_prep = (state == PREP);
   assign in_calc = (state == CALC);
   // A flush during FIX must leave the previous result untouched.
   assign commit  = (state == FIX) && !flush;

   m_ext_datapath #(
      .XLEN (XLEN)
   ) u_dp (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept),
      .prep    (in_prep),
      .calc    (in_calc),
      .commit  (commit),
      .funct3  (funct3),
      .op_a    (op_a),
      .op_b    (op_b),
      .special (special),
      .result  (result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= PREP;
                  busy  <= 1'b1;
               end
            end
            PREP: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt   <= CNT_W'(XLEN);
                  state <= special ? FIX : CALC;
               end
            end
            CALC: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  // Last of exactly XLEN iterations.
                  if (cnt == CNT_W'(1)) begin
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               // Result is already committed, so a flush here changes nothing.
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/m_ext_seq.md
Name: m_ext_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Accepts one operation from decode/execute and runs a radix-2 shift-add multiplier or a restoring divider, one bit per cycle.
- Returns a registered result with a one-cycle done pulse.
- The core holds its pipeline while busy is high; flush aborts on redirect.

Parameters:
- XLEN, 32: operand and result width. Iteration count equals XLEN.
- CNT_W, $clog2(XLEN)+1: iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe. Accepted only when busy=0 and flush=0.
- funct3  in  3  operation select, equal to m_func[2:0]:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value (multiplicand or dividend).
- op_b  in  XLEN  rs2 value (multiplier or divisor).
- flush  in  1  abort the current operation.
- busy  out  1  high from the cycle after acceptance until the cycle done is high (inclusive).
- done  out  1  single-cycle pulse; result is valid in the same cycle.
- result  out  XLEN  registered result. Holds its value until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0. Reset has priority over every other input, including mid-operation.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 → latch funct3, op_a, op_b; next state PREP.
  - Otherwise stay in IDLE.
- PREP:
  - Take absolute values of operands treated as signed: both for MULH/DIV/REM, op_a only for MULHSU. Record sign_res and sign_rem.
  - Load counter=XLEN.
  - Special cases go straight to FIX without entering CALC:
    - Divide by zero (op_b=0): DIV/DIVU → all ones; REM/REMU → op_a.
    - Signed overflow (DIV/REM with op_a=0x8000_0000, op_b=0xFFFF_FFFF): DIV → 0x8000_0000; REM → 0.
  - Otherwise next state CALC.
- CALC: one iteration per cycle; decrement counter; leave for FIX when the counter reaches 0 (exactly XLEN cycles).
  - Multiply: 2*XLEN-bit product register, shift-add on multiplier LSB.
  - Divide: restoring step using an XLEN+1-bit subtract.
- FIX:
  - Apply two's-complement negation. For multiply/quotient use sign_res; for remainder use the sign of the dividend.
  - Select the low half (MUL) or high half (MULH*) of the product, or quotient/remainder.
  - Register result; next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE.
- busy is 1 in PREP, CALC, FIX and DONE; 0 in IDLE.
- Latency, with start accepted in cycle T:
  - Normal path: done in cycle T+XLEN+3 (T+35 for XLEN=32).
  - Special-case path: done in cycle T+3.
- start while busy=1 is ignored; it is not queued. A new start is accepted in the cycle after DONE (back-to-back issue: the IDLE cycle accepts).
- flush=1 in any non-IDLE state → IDLE on the next edge. No done, result unchanged. flush in IDLE blocks acceptance of a simultaneous start.
- flush and done coincident in DONE: done still pulses, because result is already committed.
- Arithmetic is mod 2^XLEN. All operand registers are sampled only at acceptance, so input changes during busy have no effect.

Decomposition:
- Shared package riscv_pkg gets:
  - m_state_t enum (IDLE, PREP, CALC, FIX, DONE).
  - m_op_t 3-bit funct3 enum, derived from the existing m_func low bits.
  - Constants M_DIV_OVF_A=0x8000_0000 and M_ALL_ONES.
- One sub-module, m_ext_datapath: owns the shift registers, adder/subtractor and sign fix-up, and is controlled by state and counter from m_ext_seq.
- The FSM and counter stay in m_ext_seq.

Test Plan:
- MUL, op_a=7, op_b=6 → done at T+35 with result=42; busy high cycles T+1..T+35.
- MULH, op_a=0xFFFF_FFFF (-1), op_b=0x0000_0002 → result=0xFFFF_FFFF. MULHU with the same operands → result=0x0000_0001.
- DIV, op_a=-7 (0xFFFF_FFF9), op_b=2 → result=0xFFFF_FFFD (-3). REM with the same operands → 0xFFFF_FFFF (-1).
- DIVU, op_b=0, op_a=0x1234 → done at T+3, result=0xFFFF_FFFF. REMU with the same operands → 0x1234. DIV with op_a=0x8000_0000, op_b=0xFFFF_FFFF → 0x8000_0000 at T+3.
- Start DIVU 100/7. Pulse flush at T+10 → IDLE at T+11, no done, result keeps its prior value. A new start at T+11 (MUL 3*5) → result 15 at T+46.
- Assert rst at T+20 mid-DIV → next cycle busy=0, done=0, result=0. A start pulsed while busy=1 → ignored, and only one done observed.
